// File: rtl/rc4_stream_cipher.sv
// RC4 keystream generator with XOR datapath: a key schedule on request, then one WORD_W-bit
// keystream word per accepted input word, returned as in_data ^ keystream.
module rc4_stream_cipher #(
  parameter int unsigned SYM_W   = 4,
  parameter int unsigned KEY_LEN = 16,
  parameter int unsigned WORD_W  = 32
) (
  input  logic                       clk_i,
  input  logic                       reset_1_i,
  input  logic                       key_load_i,
  input  logic [KEY_LEN*SYM_W-1:0]   key_i,
  output logic                       key_ready_o,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WORD_W-1:0]          in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WORD_W-1:0]          out_data_o,
  output logic [WORD_W-1:0]          ks_out_o
);

  localparam int unsigned N    = 1 << SYM_W;
  localparam int unsigned NSYM = WORD_W / SYM_W;
  localparam int unsigned KX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam int unsigned SC_W = (NSYM > 1) ? $clog2(NSYM) : 1;

  if ((WORD_W % SYM_W) != 0 || KEY_LEN < 1) begin : g_param_check
    $fatal(1, "rc4_stream_cipher: WORD_W must be a multiple of SYM_W and KEY_LEN >= 1");
  end

  typedef enum logic [2:0] {StIdle, StInit, StKsa, StReady, StGen, StOut} state_e;

  state_e                     state_q, state_d;
  logic [SYM_W-1:0]           s_q [N];
  logic [SYM_W-1:0]           s_d [N];
  logic [SYM_W-1:0]           i_q, i_d, j_q, j_d;
  logic [KX_W-1:0]            kx_q, kx_d;
  logic [SC_W-1:0]            sc_q, sc_d;
  logic [KEY_LEN*SYM_W-1:0]   key_q, key_d;
  logic [WORD_W-1:0]          din_q, din_d;
  logic [WORD_W-1:0]          ks_q, ks_d;
  logic [WORD_W-1:0]          out_data_q, out_data_d;

  // Shared swap datapath: KSA uses (i, j + S[i] + key), GEN uses (i + 1, j + S[i + 1]).
  logic [SYM_W-1:0] i_sel, j_new, s_i, s_j, t_idx, key_sym, sym;

  always_comb begin
    i_sel   = (state_q == StGen) ? i_q + SYM_W'(1) : i_q;
    key_sym = key_q[kx_q*SYM_W +: SYM_W];
    s_i     = s_q[i_sel];
    j_new   = j_q + s_i + ((state_q == StKsa) ? key_sym : '0);
    s_j     = s_q[j_new];
    t_idx   = s_i + s_j;
    // Output symbol is read from the post-swap table without waiting a cycle.
    if (t_idx == i_sel) begin
      sym = s_j;
    end else if (t_idx == j_new) begin
      sym = s_i;
    end else begin
      sym = s_q[t_idx];
    end
  end

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    i_d        = i_q;
    j_d        = j_q;
    kx_d       = kx_q;
    sc_d       = sc_q;
    key_d      = key_q;
    din_d      = din_q;
    ks_d       = ks_q;
    out_data_d = out_data_q;

    if (key_load_i) begin
      state_d = StInit;
      key_d   = key_i;
    end else begin
      unique case (state_q)
        StIdle: state_d = StIdle;
        StInit: begin
          for (int k = 0; k < N; k++) s_d[k] = SYM_W'(k);
          i_d     = '0;
          j_d     = '0;
          kx_d    = '0;
          state_d = StKsa;
        end
        StKsa: begin
          s_d[i_sel] = s_j;
          s_d[j_new] = s_i;
          j_d        = j_new;
          i_d        = i_q + SYM_W'(1);
          kx_d       = (kx_q == KX_W'(KEY_LEN - 1)) ? '0 : kx_q + KX_W'(1);
          if (i_q == SYM_W'(N - 1)) begin
            j_d     = '0;
            state_d = StReady;
          end
        end
        StReady: begin
          if (in_valid_i) begin
            din_d   = in_data_i;
            sc_d    = '0;
            state_d = StGen;
          end
        end
        StGen: begin
          s_d[i_sel]               = s_j;
          s_d[j_new]               = s_i;
          i_d                      = i_sel;
          j_d                      = j_new;
          ks_d[sc_q*SYM_W +: SYM_W] = sym;
          if (sc_q == SC_W'(NSYM - 1)) begin
            out_data_d = din_q ^ ks_d;
            state_d    = StOut;
          end else begin
            sc_d = sc_q + SC_W'(1);
          end
        end
        StOut: begin
          if (out_ready_i) state_d = StReady;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_1_i) begin
      state_q <= StIdle;
      for (int k = 0; k < N; k++) s_q[k] <= SYM_W'(k);
      i_q        <= '0;
      j_q        <= '0;
      kx_q       <= '0;
      sc_q       <= '0;
      key_q      <= '0;
      din_q      <= '0;
      ks_q       <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      i_q        <= i_d;
      j_q        <= j_d;
      kx_q       <= kx_d;
      sc_q       <= sc_d;
      key_q      <= key_d;
      din_q      <= din_d;
      ks_q       <= ks_d;
      out_data_q <= out_data_d;
    end
  end

  assign key_ready_o = (state_q == StReady) || (state_q == StGen) || (state_q == StOut);
  assign in_ready_o  = (state_q == StReady);
  assign out_valid_o = (state_q == StOut);
  assign out_data_o  = out_data_q;
  assign ks_out_o    = ks_q;

endmodule

// File: tb/tb_rc4_stream_cipher.sv
// Scoreboarded bench: instance A (SYM_W=8, KEY_LEN=3) and instance B (default parameters),
// each checked against a plain-array RC4 model.
module tb_rc4_stream_cipher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, kl_a, iv_a, ir_a, ov_a, or_a, kr_a;
  logic [23:0] key_a;
  logic [31:0] id_a, od_a, ks_a;
  logic        rst_b, kl_b, iv_b, ir_b, ov_b, or_b, kr_b;
  logic [63:0] key_b;
  logic [31:0] id_b, od_b, ks_b;

  rc4_stream_cipher #(.SYM_W(8), .KEY_LEN(3), .WORD_W(32)) dut_a (
    .clk_i(clk), .reset_1_i(rst_a), .key_load_i(kl_a), .key_i(key_a), .key_ready_o(kr_a),
    .in_valid_i(iv_a), .in_ready_o(ir_a), .in_data_i(id_a), .out_valid_o(ov_a),
    .out_ready_i(or_a), .out_data_o(od_a), .ks_out_o(ks_a)
  );

  rc4_stream_cipher dut_b (
    .clk_i(clk), .reset_1_i(rst_b), .key_load_i(kl_b), .key_i(key_b), .key_ready_o(kr_b),
    .in_valid_i(iv_b), .in_ready_o(ir_b), .in_data_i(id_b), .out_valid_o(ov_b),
    .out_ready_i(or_b), .out_data_o(od_b), .ks_out_o(ks_b)
  );

  int total = 0;
  int bad   = 0;
  int rdy_mode_b = 1;
  logic [63:0] q_a[$];
  logic [63:0] q_b[$];
  logic [63:0] ea, eb, e4;
  logic [31:0] ks, ct, d4;
  logic [63:0] kr;

  // Reference model: textbook RC4 on plain int arrays, one table per instance.
  int ms[2][256];
  int mi[2];
  int mj[2];
  int symw[2] = '{8, 4};
  int klen[2] = '{3, 16};

  function automatic void m_ksa(int n, logic [63:0] k);
    int nn = 1 << symw[n];
    int j = 0;
    int t;
    int ksym;
    for (int x = 0; x < nn; x++) ms[n][x] = x;
    for (int x = 0; x < nn; x++) begin
      ksym = int'((k >> ((x % klen[n]) * symw[n])) & 64'(nn - 1));
      j = (j + ms[n][x] + ksym) % nn;
      t = ms[n][x]; ms[n][x] = ms[n][j]; ms[n][j] = t;
    end
    mi[n] = 0;
    mj[n] = 0;
  endfunction

  function automatic logic [31:0] m_word(int n);
    int nn = 1 << symw[n];
    int t;
    logic [31:0] w = '0;
    for (int s = 0; s < 32 / symw[n]; s++) begin
      mi[n] = (mi[n] + 1) % nn;
      mj[n] = (mj[n] + ms[n][mi[n]]) % nn;
      t = ms[n][mi[n]]; ms[n][mi[n]] = ms[n][mj[n]]; ms[n][mj[n]] = t;
      w = w | (32'(ms[n][(ms[n][mi[n]] + ms[n][mj[n]]) % nn]) << (s * symw[n]));
    end
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic sig_kr(int n); return (n == 0) ? kr_a : kr_b; endfunction
  function automatic logic sig_ir(int n); return (n == 0) ? ir_a : ir_b; endfunction

  task automatic set_kl(input int n, input logic v);
    if (n == 0) kl_a = v; else kl_b = v;
  endtask

  task automatic set_in(input int n, input logic v, input logic [31:0] d);
    if (n == 0) begin iv_a = v; id_a = d; end
    else begin iv_b = v; id_b = d; end
  endtask

  task automatic load_key(input int n, input logic [63:0] k, input bit chk_lat);
    int cnt;
    if (n == 0) key_a = k[23:0]; else key_b = k;
    set_kl(n, 1'b1);
    @(posedge clk); #1;
    set_kl(n, 1'b0);
    cnt = 1;
    while (!sig_kr(n) && cnt < 600) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (!sig_kr(n)) chk("key_ready timeout", 32'(sig_kr(n)), 32'd1);
    if (chk_lat) chk("ksa latency", cnt, (1 << symw[n]) + 2);
    m_ksa(n, k);
  endtask

  task automatic send(input int n, input logic [31:0] d, input bit fks_en,
                      input logic [31:0] fks, input bit fod_en, input logic [31:0] fod,
                      output logic [31:0] kso);
    int cnt = 0;
    logic [63:0] e;
    set_in(n, 1'b1, d);
    while (!sig_ir(n) && cnt < 2000) begin
      @(posedge clk); #1;
      cnt++;
    end
    kso = '0;
    if (!sig_ir(n)) begin
      chk("in_ready timeout", 32'(sig_ir(n)), 32'd1);
      set_in(n, 1'b0, d);
      return;
    end
    kso = m_word(n);
    e = {fks_en ? fks : kso, fod_en ? fod : (d ^ kso)};
    if (n == 0) q_a.push_back(e); else q_b.push_back(e);
    @(posedge clk); #1;
    set_in(n, 1'b0, d);
  endtask

  task automatic wait_idle(input int n);
    int cnt = 0;
    while (((n == 0 ? q_a.size() : q_b.size()) != 0 || !sig_ir(n)) && cnt < 2000) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (cnt >= 2000) chk("drain timeout", 32'(n == 0 ? q_a.size() : q_b.size()), 32'd0);
  endtask

  // Monitors: pop and compare on every completed output handshake.
  always @(negedge clk) begin
    if (ov_a && or_a) begin
      if (q_a.size() == 0) chk("A spurious out_valid", 32'(ov_a), 32'd0);
      else begin
        ea = q_a.pop_front();
        chk("A ks_out", ks_a, ea[63:32]);
        chk("A out_data", od_a, ea[31:0]);
      end
    end
    if (ov_b && or_b) begin
      if (q_b.size() == 0) chk("B spurious out_valid", 32'(ov_b), 32'd0);
      else begin
        eb = q_b.pop_front();
        chk("B ks_out", ks_b, eb[63:32]);
        chk("B out_data", od_b, eb[31:0]);
      end
    end
  end

  initial begin
    or_b = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode_b)
        0:       or_b = 1'b0;
        1:       or_b = 1'b1;
        default: or_b = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #1000000;
    $display("FAIL global timeout: total=%0d", total);
    $fatal(1, "timeout");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; kl_a = 1'b0; kl_b = 1'b0;
    iv_a = 1'b0; iv_b = 1'b0; id_a = '0; id_b = '0; key_a = '0; key_b = '0; or_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;
    @(posedge clk); #1;
    chk("A reset key_ready", 32'(kr_a), 32'd0);
    chk("A reset in_ready", 32'(ir_a), 32'd0);
    chk("A reset out_valid", 32'(ov_a), 32'd0);
    chk("A reset out_data", od_a, 32'd0);
    chk("A reset ks_out", ks_a, 32'd0);
    chk("B reset key_ready", 32'(kr_b), 32'd0);
    chk("B reset in_ready", 32'(ir_b), 32'd0);
    chk("B reset out_valid", 32'(ov_b), 32'd0);

    // Known "Key" vector, then continuation word.
    load_key(0, 64'h79654B, 1);
    send(0, 32'h69616C50, 1, 32'h81779FEB, 1, 32'hE816F3BB, ks);
    send(0, 32'h00000000, 1, 32'h72CA34B7, 1, 32'h72CA34B7, ks);
    wait_idle(0);

    // Abort mid-GEN: the pending word must never appear.
    send(0, 32'h12345678, 0, '0, 0, '0, ks);
    @(posedge clk); #1;
    void'(q_a.pop_back());
    load_key(0, 64'h79654B, 0);
    send(0, 32'h69616C50, 1, 32'h81779FEB, 1, 32'hE816F3BB, ks);
    wait_idle(0);

    // Encrypt / reload / decrypt round trip on default parameters.
    load_key(1, 64'h0123456789ABCDEF, 1);
    send(1, 32'h4BC51EF9, 0, '0, 0, '0, ks);
    ct = 32'h4BC51EF9 ^ ks;
    wait_idle(1);
    load_key(1, 64'h0123456789ABCDEF, 0);
    send(1, ct, 0, '0, 1, 32'h4BC51EF9, ks);
    wait_idle(1);

    // Output stall: hold out_ready low for 10 cycles in OUT.
    rdy_mode_b = 0;
    repeat (2) @(posedge clk);
    #1;
    d4 = $urandom();
    send(1, d4, 0, '0, 0, '0, ks);
    e4 = q_b[0];
    for (int c = 0; c < 50 && !ov_b; c++) begin
      @(posedge clk); #1;
    end
    chk("B stall out_valid", 32'(ov_b), 32'd1);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("B stall ks_out", ks_b, e4[63:32]);
      chk("B stall out_data", od_b, e4[31:0]);
      chk("B stall in_ready", 32'(ir_b), 32'd0);
    end
    rdy_mode_b = 1;
    send(1, $urandom(), 0, '0, 0, '0, ks);
    wait_idle(1);

    // Random words with random backpressure and occasional rekeying.
    rdy_mode_b = 2;
    for (int w = 0; w < 40; w++) begin
      if ($urandom_range(0, 7) == 0) begin
        wait_idle(1);
        kr = {$urandom(), $urandom()};
        load_key(1, kr, 1);
      end
      send(1, $urandom(), 0, '0, 0, '0, ks);
    end
    wait_idle(1);
    rdy_mode_b = 1;

    // Reset mid-KSA, with in_valid held high throughout.
    key_b = 64'hFEDCBA9876543210;
    kl_b = 1'b1;
    @(posedge clk); #1;
    kl_b = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_b = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    chk("B rst key_ready", 32'(kr_b), 32'd0);
    chk("B rst out_valid", 32'(ov_b), 32'd0);
    chk("B rst in_ready", 32'(ir_b), 32'd0);
    d4 = $urandom();
    iv_b = 1'b1; id_b = d4;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("B idle in_ready", 32'(ir_b), 32'd0);
    end
    load_key(1, 64'hFEDCBA9876543210, 1);
    send(1, d4, 0, '0, 0, '0, ks);
    wait_idle(1);

    chk("A queue empty", 32'(q_a.size()), 32'd0);
    chk("B queue empty", 32'(q_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
